// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM state codes, opcodes,
// ALU operand/operation selects and the instruction class used for sequencing.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_LOAD_MEM = 4'd3,
        S_LOAD_WB  = 4'd4,
        S_STORE    = 4'd5,
        S_ALU_EXEC = 4'd6,
        S_ALU_WB   = 4'd7,
        S_ORI_EXEC = 4'd8,
        S_ORI_WB   = 4'd9,
        S_SH_EXEC  = 4'd10,
        S_SH_WB    = 4'd11,
        S_BR_EVAL  = 4'd12,
        S_HALT     = 4'd13
    } state_t;

    typedef enum logic [3:0] {
        CL_LOAD,
        CL_STORE,
        CL_RTYPE,
        CL_ORI,
        CL_SHIFT,
        CL_BZ,
        CL_BNZ,
        CL_BPZ,
        CL_STOP,
        CL_NOP
    } iclass_t;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_NAND  = 4'b1000;
    localparam logic [3:0] OP_BZ    = 4'b0101;
    localparam logic [3:0] OP_BNZ   = 4'b1001;
    localparam logic [3:0] OP_BPZ   = 4'b1101;
    localparam logic [3:0] OP_STOP  = 4'b0001;
    localparam logic [3:0] OP_NOP   = 4'b1010;

    localparam logic [2:0] ALU2_R2    = 3'b000;
    localparam logic [2:0] ALU2_ONE   = 3'b001;
    localparam logic [2:0] ALU2_SIMM4 = 3'b010;
    localparam logic [2:0] ALU2_ZIMM5 = 3'b011;
    localparam logic [2:0] ALU2_SHAMT = 3'b100;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_OR    = 3'b010;
    localparam logic [2:0] ALUOP_NAND  = 3'b011;
    localparam logic [2:0] ALUOP_SHIFT = 3'b100;

    // States after which the instruction is complete and the FSM returns to FETCH.
    function automatic logic is_terminal(input state_t s);
        return (s == S_LOAD_WB) || (s == S_STORE) || (s == S_ALU_WB) ||
               (s == S_ORI_WB) || (s == S_SH_WB) || (s == S_BR_EVAL);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode-to-class mapping; unlisted opcodes fall through to nop.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] i_opcode,
    output iclass_t    o_class
);

    always_comb begin
        o_class = CL_NOP;
        casez (i_opcode)
            4'b0000: o_class = CL_LOAD;
            4'b0010: o_class = CL_STORE;
            4'b0100,
            4'b0110,
            4'b1000: o_class = CL_RTYPE;
            4'b?111: o_class = CL_ORI;
            4'b?011: o_class = CL_SHIFT;
            4'b0101: o_class = CL_BZ;
            4'b1001: o_class = CL_BNZ;
            4'b1101: o_class = CL_BPZ;
            4'b0001: o_class = CL_STOP;
            default: o_class = CL_NOP;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle processor control FSM: Moore strobes per state, branch PCWrite from flags.
// Optional retired-instruction counter enabled by defining MC_CTRL_PERF_EN.
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] instr,
    input  logic       N,
    input  logic       Z,
    output logic       PCWrite,
    output logic       AddrSel,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRLoad,
    output logic       MDRLoad,
    output logic       R1Sel,
    output logic       RFWrite,
    output logic       RegIn,
    output logic       ALU1,
    output logic       ALUOutWrite,
    output logic       FlagWrite,
    output logic [2:0] ALU2,
    output logic [2:0] ALUOp,
    output logic       halted,
    output logic [3:0] state
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [15:0] retired
`endif
);

    state_t  r_state;
    state_t  w_next;
    iclass_t w_class;
    logic    w_taken;
    logic    w_unused;

    // Upper IR bits carry register/immediate fields the datapath consumes directly.
    assign w_unused = ^instr[7:4];

    mc_ctrl_decode u_decode (
        .i_opcode (instr[3:0]),
        .o_class  (w_class)
    );

    always_comb begin
        w_taken = 1'b0;
        case (w_class)
            CL_BZ:   w_taken = Z;
            CL_BNZ:  w_taken = ~Z;
            CL_BPZ:  w_taken = ~N;
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_RESET;
        case (r_state)
            S_RESET:  w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (w_class)
                    CL_LOAD:  w_next = S_LOAD_MEM;
                    CL_STORE: w_next = S_STORE;
                    CL_RTYPE: w_next = S_ALU_EXEC;
                    CL_ORI:   w_next = S_ORI_EXEC;
                    CL_SHIFT: w_next = S_SH_EXEC;
                    CL_BZ,
                    CL_BNZ,
                    CL_BPZ:   w_next = S_BR_EVAL;
                    CL_STOP:  w_next = S_HALT;
                    default:  w_next = S_FETCH;
                endcase
            end
            S_LOAD_MEM: w_next = S_LOAD_WB;
            S_ALU_EXEC: w_next = S_ALU_WB;
            S_ORI_EXEC: w_next = S_ORI_WB;
            S_SH_EXEC:  w_next = S_SH_WB;
            S_LOAD_WB,
            S_STORE,
            S_ALU_WB,
            S_ORI_WB,
            S_SH_WB,
            S_BR_EVAL:  w_next = S_FETCH;
            S_HALT:     w_next = S_HALT;
            default:    w_next = S_RESET;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        AddrSel     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRLoad      = 1'b0;
        MDRLoad     = 1'b0;
        R1Sel       = 1'b0;
        RFWrite     = 1'b0;
        RegIn       = 1'b0;
        ALU1        = 1'b0;
        ALUOutWrite = 1'b0;
        FlagWrite   = 1'b0;
        ALU2        = ALU2_R2;
        ALUOp       = ALUOP_ADD;
        halted      = 1'b0;
        state       = r_state;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                IRLoad  = 1'b1;
                AddrSel = 1'b1;
                ALU2    = ALU2_ONE;
                PCWrite = 1'b1;
            end
            S_DECODE: R1Sel = (w_class == CL_ORI);
            S_LOAD_MEM: begin
                MemRead = 1'b1;
                MDRLoad = 1'b1;
            end
            S_LOAD_WB: begin
                RFWrite = 1'b1;
                RegIn   = 1'b1;
            end
            S_STORE: MemWrite = 1'b1;
            S_ALU_EXEC: begin
                ALU1        = 1'b1;
                ALUOutWrite = 1'b1;
                FlagWrite   = 1'b1;
                // IR is stable through execution, so the R-type op comes from it.
                case (instr[3:0])
                    OP_SUB:  ALUOp = ALUOP_SUB;
                    OP_NAND: ALUOp = ALUOP_NAND;
                    default: ALUOp = ALUOP_ADD;
                endcase
            end
            S_ORI_EXEC: begin
                ALU1        = 1'b1;
                ALU2        = ALU2_ZIMM5;
                ALUOp       = ALUOP_OR;
                ALUOutWrite = 1'b1;
                FlagWrite   = 1'b1;
            end
            S_SH_EXEC: begin
                ALU1        = 1'b1;
                ALU2        = ALU2_SHAMT;
                ALUOp       = ALUOP_SHIFT;
                ALUOutWrite = 1'b1;
                FlagWrite   = 1'b1;
            end
            S_ALU_WB,
            S_ORI_WB,
            S_SH_WB:  RFWrite = 1'b1;
            S_BR_EVAL: begin
                ALU2    = ALU2_SIMM4;
                PCWrite = w_taken;
            end
            S_HALT:   halted = 1'b1;
            default: ;
        endcase
    end

`ifdef MC_CTRL_PERF_EN
    logic [15:0] r_retired;
    logic        w_retire;

    assign w_retire = is_terminal(r_state) ||
                      ((r_state == S_DECODE) && (w_class == CL_NOP));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_retired <= 16'h0000;
        end else if (w_retire && (r_retired != 16'hFFFF)) begin
            r_retired <= r_retired + 16'h0001;
        end
    end

    assign retired = r_retired;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller (optionally with MC_CTRL_PERF_EN).
module tb_mc_controller;
    import mc_ctrl_pkg::*;

    logic       clock;
    logic       reset;
    logic [7:0] instr;
    logic       N;
    logic       Z;
    logic       PCWrite, AddrSel, MemRead, MemWrite, IRLoad, MDRLoad;
    logic       R1Sel, RFWrite, RegIn, ALU1, ALUOutWrite, FlagWrite;
    logic [2:0] ALU2;
    logic [2:0] ALUOp;
    logic       halted;
    logic [3:0] state;
`ifdef MC_CTRL_PERF_EN
    logic [15:0] retired;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mc_controller dut (
        .clock       (clock),
        .reset       (reset),
        .instr       (instr),
        .N           (N),
        .Z           (Z),
        .PCWrite     (PCWrite),
        .AddrSel     (AddrSel),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRLoad      (IRLoad),
        .MDRLoad     (MDRLoad),
        .R1Sel       (R1Sel),
        .RFWrite     (RFWrite),
        .RegIn       (RegIn),
        .ALU1        (ALU1),
        .ALUOutWrite (ALUOutWrite),
        .FlagWrite   (FlagWrite),
        .ALU2        (ALU2),
        .ALUOp       (ALUOp),
        .halted      (halted),
        .state       (state)
`ifdef MC_CTRL_PERF_EN
        ,
        .retired     (retired)
`endif
    );

    // {PCWrite,AddrSel,MemRead,MemWrite,IRLoad,MDRLoad,R1Sel,RFWrite,RegIn,ALU1,ALUOutWrite,FlagWrite}
    logic [11:0] strb;
    assign strb = {PCWrite, AddrSel, MemRead, MemWrite, IRLoad, MDRLoad,
                   R1Sel, RFWrite, RegIn, ALU1, ALUOutWrite, FlagWrite};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Check the current cycle's state and outputs, then advance one clock.
    task automatic cyc(input string tag, input state_t s, input logic [11:0] st,
                       input logic [2:0] a2, input logic [2:0] op);
        chk({tag, ".state"}, {28'd0, state}, {28'd0, s});
        chk({tag, ".strb"}, {20'd0, strb}, {20'd0, st});
        chk({tag, ".alu2"}, {29'd0, ALU2}, {29'd0, a2});
        chk({tag, ".aluop"}, {29'd0, ALUOp}, {29'd0, op});
        tick();
    endtask

    task automatic fetch_decode(input string tag, input logic [7:0] op, input logic [11:0] dec_strb);
        instr = op;
        cyc({tag, ".fetch"}, S_FETCH, 12'hE80, 3'b001, 3'b000);
        cyc({tag, ".decode"}, S_DECODE, dec_strb, 3'b000, 3'b000);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        instr = 8'h00;
        N     = 1'b0;
        Z     = 1'b0;
        #12;
        chk("rst.state", {28'd0, state}, 32'd0);
        chk("rst.strb", {20'd0, strb}, 32'd0);
        chk("rst.alu2", {29'd0, ALU2}, 32'd0);
        chk("rst.aluop", {29'd0, ALUOp}, 32'd0);
        chk("rst.halted", {31'd0, halted}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rel.state_wait", {28'd0, state}, 32'd0);
        tick();

        fetch_decode("add", 8'h04, 12'h000);
        cyc("add.exec", S_ALU_EXEC, 12'h007, 3'b000, 3'b000);
        cyc("add.wb", S_ALU_WB, 12'h010, 3'b000, 3'b000);

        fetch_decode("sub", 8'h06, 12'h000);
        cyc("sub.exec", S_ALU_EXEC, 12'h007, 3'b000, 3'b001);
        cyc("sub.wb", S_ALU_WB, 12'h010, 3'b000, 3'b000);

        fetch_decode("nand", 8'h08, 12'h000);
        cyc("nand.exec", S_ALU_EXEC, 12'h007, 3'b000, 3'b011);
        cyc("nand.wb", S_ALU_WB, 12'h010, 3'b000, 3'b000);

        fetch_decode("load", 8'h00, 12'h000);
        cyc("load.mem", S_LOAD_MEM, 12'h240, 3'b000, 3'b000);
        cyc("load.wb", S_LOAD_WB, 12'h018, 3'b000, 3'b000);

        fetch_decode("store", 8'h02, 12'h000);
        cyc("store.mem", S_STORE, 12'h100, 3'b000, 3'b000);

        fetch_decode("ori", 8'hF7, 12'h020);
        cyc("ori.exec", S_ORI_EXEC, 12'h007, 3'b011, 3'b010);
        cyc("ori.wb", S_ORI_WB, 12'h010, 3'b000, 3'b000);

        fetch_decode("shift", 8'h0B, 12'h000);
        cyc("shift.exec", S_SH_EXEC, 12'h007, 3'b100, 3'b100);
        cyc("shift.wb", S_SH_WB, 12'h010, 3'b000, 3'b000);

        fetch_decode("nop", 8'h0A, 12'h000);
        fetch_decode("undef", 8'h0C, 12'h000);

        Z = 1'b1;
        fetch_decode("bz_t", 8'h05, 12'h000);
        cyc("bz_t.br", S_BR_EVAL, 12'h800, 3'b010, 3'b000);
        Z = 1'b0;
        fetch_decode("bz_n", 8'h05, 12'h000);
        chk("bz_n.pcw", {31'd0, PCWrite}, 32'd0);
        Z = 1'b1;
        #1;
        chk("bz.comb_pcw", {31'd0, PCWrite}, 32'd1);
        Z = 1'b0;
        #1;
        cyc("bz_n.br", S_BR_EVAL, 12'h000, 3'b010, 3'b000);
        fetch_decode("bnz_t", 8'h09, 12'h000);
        cyc("bnz_t.br", S_BR_EVAL, 12'h800, 3'b010, 3'b000);
        N = 1'b1;
        fetch_decode("bpz_n", 8'h0D, 12'h000);
        cyc("bpz_n.br", S_BR_EVAL, 12'h000, 3'b010, 3'b000);
        N = 1'b0;
        fetch_decode("bpz_t", 8'h0D, 12'h000);
        cyc("bpz_t.br", S_BR_EVAL, 12'h800, 3'b010, 3'b000);

        // Asynchronous reset in the middle of ALU_EXEC.
        fetch_decode("arst", 8'h04, 12'h000);
        chk("arst.pre", {28'd0, state}, {28'd0, S_ALU_EXEC});
        #2;
        reset = 1'b0;
        #1;
        chk("arst.state", {28'd0, state}, 32'd0);
        chk("arst.strb", {20'd0, strb}, 32'd0);
        #2;
        reset = 1'b1;
        tick();

        fetch_decode("stop", 8'h01, 12'h000);
        for (int i = 0; i < 20; i++) begin
            chk("halt.state", {28'd0, state}, {28'd0, S_HALT});
            chk("halt.flag", {31'd0, halted}, 32'd1);
            chk("halt.strb", {20'd0, strb}, 32'd0);
            tick();
        end
        #2;
        reset = 1'b0;
        #1;
        chk("hrst.state", {28'd0, state}, 32'd0);
        chk("hrst.halted", {31'd0, halted}, 32'd0);
        #2;
        reset = 1'b1;
        tick();
        chk("hrst.fetch", {28'd0, state}, {28'd0, S_FETCH});

`ifdef MC_CTRL_PERF_EN
        do_reset();
        chk("perf.rst", {16'd0, retired}, 32'd0);
        fetch_decode("p_add", 8'h04, 12'h000);
        cyc("p_add.exec", S_ALU_EXEC, 12'h007, 3'b000, 3'b000);
        cyc("p_add.wb", S_ALU_WB, 12'h010, 3'b000, 3'b000);
        fetch_decode("p_nop", 8'h0A, 12'h000);
        Z = 1'b1;
        fetch_decode("p_bz", 8'h05, 12'h000);
        cyc("p_bz.br", S_BR_EVAL, 12'h800, 3'b010, 3'b000);
        Z = 1'b0;
        fetch_decode("p_stop", 8'h01, 12'h000);
        tick();
        chk("perf.count", {16'd0, retired}, 32'd3);

        do_reset();
        force dut.r_retired = 16'hFFFD;
        #1;
        release dut.r_retired;
        for (int i = 0; i < 4; i++) begin
            fetch_decode("p_sat", 8'h0A, 12'h000);
        end
        chk("perf.sat", {16'd0, retired}, 32'h0000FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
